clkswitch_req: RTL

CLKSWITCH_REQ -- requirements
Module: clkswitch_req

---
 rtl/clkswitch_req_pkg.sv | 20 ++
 rtl/clkswitch_req_status_sync.sv | 27 ++
 rtl/clkswitch_req.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clkswitch_req_pkg.sv
// Shared definitions for the CPU clock-speed switch controller:
// FSM state encoding and default timing parameters.
package clkswitch_req_pkg;

    typedef enum logic [1:0] {
        HS_RUN = 2'd0,
        TO_LS  = 2'd1,
        LS_RUN = 2'd2,
        TO_HS  = 2'd3
    } cs_state_t;

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_HOLDOFF_CYCLES = 4;

    // True in the two states where a clock handover is in flight.
    function automatic logic is_transition(input cs_state_t s);
        return (s == TO_LS) || (s == TO_HS);
    endfunction

endpackage

// File: rtl/clkswitch_req_status_sync.sv
// Multi-flop synchroniser for one asynchronous retimer select status bit.
// Depth is clamped to at least two flops.
module status_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;

    // Shift the asynchronous status through the flop chain.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/clkswitch_req.sv
// CPU clock-speed switch request controller.
// Drops the CPU to the low-speed clock for low-speed memory/IO cycles and
// returns to high speed once the access is done, waiting for the retimer
// select status to confirm each handover.
// Optional feature: define CLKSWITCH_HOLDOFF_EN to enforce a minimum
// low-speed dwell of HOLDOFF_CYCLES completed CPU cycles.
//
// Handover protocol: hienable is the request (1 = high speed, 0 = low
// speed); the synchronised pair {hiselect, loselect} is the acknowledge.
// A handover completes only when the selects show exactly the requested
// clock (one high, the other low). The request never changes while a
// handover is in flight, and stall is high for that whole interval.
module clkswitch_req
    import clkswitch_req_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       lo_access,
    input  logic       cycle_end,
    input  logic       loselect,
    input  logic       hiselect,
    output logic       hienable,
    output logic       stall,
    output logic       timeout_err,
    output logic [1:0] state
);

    localparam logic [7:0] TMO_MAX = 8'(TIMEOUT_CYCLES);

    cs_state_t  state_q;
    logic [7:0] wait_cnt;
    logic       lo_s;
    logic       hi_s;
    logic       dwell_last;

    status_sync #(.STAGES(SYNC_STAGES)) u_lo_sync (
        .clk   (clk),
        .rst_b (rst_b),
        .d     (loselect),
        .q     (lo_s)
    );

    status_sync #(.STAGES(SYNC_STAGES)) u_hi_sync (
        .clk   (clk),
        .rst_b (rst_b),
        .d     (hiselect),
        .q     (hi_s)
    );

`ifdef CLKSWITCH_HOLDOFF_EN
    // The dwell counter holds completed low-speed cycles; the strobe that
    // completes the HOLDOFF_CYCLES-th cycle is itself allowed to exit.
    localparam logic [7:0] HOLD_MAX  = 8'(HOLDOFF_CYCLES);
    localparam logic [7:0] HOLD_LAST = (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

    logic [7:0] dwell_cnt;

    // Count cycle_end strobes while in LS_RUN, saturating at HOLDOFF_CYCLES.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dwell_cnt <= 8'd0;
        end else if (state_q != LS_RUN) begin
            dwell_cnt <= 8'd0;
        end else if (cycle_end && (dwell_cnt != HOLD_MAX)) begin
            dwell_cnt <= dwell_cnt + 8'd1;
        end
    end

    assign dwell_last = (dwell_cnt >= HOLD_LAST);
`else
    assign dwell_last = 1'b1;
`endif

    // Switch FSM with registered request, stall and sticky timeout flag.
    // After reset the FSM sits in HS_RUN with hienable low; that pairing
    // only occurs out of reset and triggers the boot handover to high speed.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= HS_RUN;
            hienable    <= 1'b0;
            stall       <= 1'b0;
            timeout_err <= 1'b0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state_q)
                HS_RUN: begin
                    if (!hienable) begin
                        hienable <= 1'b1;
                        stall    <= 1'b1;
                        wait_cnt <= 8'd0;
                        state_q  <= TO_HS;
                    end else if (lo_access && cycle_end) begin
                        hienable <= 1'b0;
                        stall    <= 1'b1;
                        wait_cnt <= 8'd0;
                        state_q  <= TO_LS;
                    end
                end
                TO_LS: begin
                    if (lo_s && !hi_s) begin
                        stall   <= 1'b0;
                        state_q <= LS_RUN;
                    end else if (wait_cnt != TMO_MAX) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if ((wait_cnt + 8'd1) == TMO_MAX) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                LS_RUN: begin
                    if (cycle_end && !lo_access && dwell_last) begin
                        hienable <= 1'b1;
                        stall    <= 1'b1;
                        wait_cnt <= 8'd0;
                        state_q  <= TO_HS;
                    end
                end
                TO_HS: begin
                    if (hi_s && !lo_s) begin
                        stall   <= 1'b0;
                        state_q <= HS_RUN;
                    end else if (wait_cnt != TMO_MAX) begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if ((wait_cnt + 8'd1) == TMO_MAX) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= HS_RUN;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
